// File: rtl/ex_mem_stage.sv
// Execute stage of a five-stage MIPS-style pipeline plus the EX/MEM pipeline register.
// Forwarded operands feed the ALU; the result, store data, destination and branch decision are registered.
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        Regdst,
    input  logic        beq,
    input  logic        bne,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic [1:0]  ALUOp,
    input  logic        ALUsrc,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] imm,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic [1:0]  fwd_a,
    input  logic [1:0]  fwd_b,
    input  logic [31:0] wb_data,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [4:0]  dst_addr_out,
    output logic [31:0] branch_target_out,
    output logic        pc_src_out,
    output logic        MemReadout,
    output logic        MemWriteout,
    output logic        MemtoRegout,
    output logic        RegWriteout
);

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [31:0] r_alu_result;
    logic [31:0] r_store_data;
    logic [4:0]  r_dst_addr;
    logic [31:0] r_branch_target;
    logic        r_pc_src;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_mem_to_reg;
    logic        r_reg_write;

    logic [31:0] w_op_a;
    logic [31:0] w_op_bf;
    logic [31:0] w_op_b;
    logic [31:0] w_alu_result;
    logic        w_zero;
    logic        w_taken;
    logic [4:0]  w_dst_addr;
    logic [31:0] w_branch_target;

    // Select 01 loops back the value currently held in the pipeline register.
    function automatic logic [31:0] fwd_mux(input logic [1:0] sel,
                                            input logic [31:0] reg_val,
                                            input logic [31:0] mem_val,
                                            input logic [31:0] wb_val);
        logic [31:0] v;
        case (sel)
            2'b01:   v = mem_val;
            2'b10:   v = wb_val;
            default: v = reg_val;
        endcase
        return v;
    endfunction

    always_comb begin
        w_op_a  = fwd_mux(fwd_a, rs_data, r_alu_result, wb_data);
        w_op_bf = fwd_mux(fwd_b, rt_data, r_alu_result, wb_data);
        w_op_b  = ALUsrc ? imm : w_op_bf;
    end

    always_comb begin
        w_alu_result = 32'd0;
        case (ALUOp)
            ALUOP_ADD: w_alu_result = w_op_a + w_op_b;
            ALUOP_SUB: w_alu_result = w_op_a - w_op_b;
            ALUOP_OR:  w_alu_result = w_op_a | w_op_b;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD:  w_alu_result = w_op_a + w_op_b;
                    FN_SUB:  w_alu_result = w_op_a - w_op_b;
                    FN_AND:  w_alu_result = w_op_a & w_op_b;
                    FN_OR:   w_alu_result = w_op_a | w_op_b;
                    FN_NOR:  w_alu_result = ~(w_op_a | w_op_b);
                    FN_SLT:  w_alu_result = {31'd0, ($signed(w_op_a) < $signed(w_op_b))};
                    FN_SLL:  w_alu_result = w_op_b << shamt;
                    FN_SRL:  w_alu_result = w_op_b >> shamt;
                    default: w_alu_result = 32'd0;
                endcase
            end
            default: w_alu_result = 32'd0;
        endcase
    end

    always_comb begin
        w_zero          = (w_alu_result == 32'd0);
        w_taken         = (beq & w_zero) | (bne & ~w_zero);
        w_dst_addr      = Regdst ? rd_addr : rt_addr;
        w_branch_target = pc_plus4 + {imm[29:0], 2'b00};
    end

    // Reset outranks flush, flush outranks stall.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_alu_result    <= 32'd0;
            r_store_data    <= 32'd0;
            r_dst_addr      <= 5'd0;
            r_branch_target <= 32'd0;
            r_pc_src        <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_reg_write     <= 1'b0;
        end else if (!stall) begin
            r_alu_result    <= w_alu_result;
            r_store_data    <= w_op_bf;
            r_dst_addr      <= w_dst_addr;
            r_branch_target <= w_branch_target;
            r_pc_src        <= w_taken;
            r_mem_read      <= MemRead;
            r_mem_write     <= MemWrite;
            r_mem_to_reg    <= MemtoReg;
            r_reg_write     <= RegWrite;
        end
    end

    assign alu_result_out    = r_alu_result;
    assign store_data_out    = r_store_data;
    assign dst_addr_out      = r_dst_addr;
    assign branch_target_out = r_branch_target;
    assign pc_src_out        = r_pc_src;
    assign MemReadout        = r_mem_read;
    assign MemWriteout       = r_mem_write;
    assign MemtoRegout       = r_mem_to_reg;
    assign RegWriteout       = r_reg_write;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 stall  in  1  hold all registered outputs.
REQ-004 flush  in  1  insert bubble into EX/MEM register.
REQ-005 Regdst  in  1  1: destination is rd_addr; 0: destination is rt_addr.
REQ-006 beq  in  1  branch if ALU result is zero.
REQ-007 bne  in  1  branch if ALU result is non-zero.
REQ-008 MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  control bits, passed through.
REQ-009 ALUOp  in  2  00 add, 01 sub, 10 R-type (funct decode), 11 or.
REQ-010 ALUsrc  in  1  1: operand B is imm; 0: operand B is forwarded rt.
REQ-011 pc_plus4  in  32  PC of the instruction in EX, plus 4.
REQ-012 rs_data, rt_data  in  32 each  register-file read data.
REQ-013 imm  in  32  sign-extended immediate.
REQ-014 shamt  in  5  shift amount.
REQ-015 funct  in  6  R-type function field.
REQ-016 rt_addr, rd_addr  in  5 each  candidate destination registers.
REQ-017 fwd_a, fwd_b  in  2 each  operand select: 00 register data, 01 alu_result_out, 10 wb_data, 11 register data.
REQ-018 wb_data  in  32  write-back stage result.
REQ-019 alu_result_out  out  32  registered ALU result.
REQ-020 store_data_out  out  32  registered forwarded rt value, selected before the ALUsrc mux.
REQ-021 dst_addr_out  out  5  registered destination register.
REQ-022 branch_target_out  out  32  registered pc_plus4 + (imm << 2).
REQ-023 pc_src_out  out  1  registered branch-taken flag.
REQ-024 MemReadout, MemWriteout, MemtoRegout, RegWriteout  out  1 each  registered control bits.

Function
REQ-025 Operands: A = mux(fwd_a); Bf = mux(fwd_b); B = ALUsrc ? imm : Bf. Select 01 uses the current registered alu_result_out.
REQ-026 ALUOp 10 decode:
- 0x20 add; 0x22 sub; 0x24 and; 0x25 or; 0x27 nor.
- 0x2A slt: signed compare, result 1/0.
- 0x00 sll: B << shamt; 0x02 srl: B >> shamt (logical).
- Any other funct gives result 0.
REQ-027 Width rules: all arithmetic is 32-bit modulo 2^32; overflow is ignored; the branch target wraps.
REQ-028 zero = (ALU result == 0); taken = (beq & zero) | (bne & ~zero); if beq and bne are both 1, taken = 1.
REQ-029 Destination: dst = Regdst ? rd_addr : rt_addr.
REQ-030 Register update priority: reset > flush > stall > load. Latency is 1 cycle from inputs to outputs.
REQ-031 Flush: all outputs are set to 0 on the next edge (bubble); flush overrides stall.
REQ-032 Stall: all outputs hold their values. Forwarding select 01 continues to see the held alu_result_out.
REQ-033 Load: all outputs capture the computed values.

Reset
REQ-034 When rst_n=0 at a clock edge, every output is set to 0, including pc_src_out and all control outputs.
REQ-035 Reset asserted mid-stall or mid-flush still clears all outputs. The first load occurs on the first edge with rst_n=1.

Verification
REQ-036 Add:
- Stimulus: ALUOp=10, funct=0x20, rs=5, rt=7, fwd=00, RegWrite=1, Regdst=1, rd=3.
- Next cycle: alu_result_out=12, dst_addr_out=3, RegWriteout=1.
REQ-037 Branch:
- beq=1, ALUOp=01, rs=rt=9, pc_plus4=0x100, imm=0xFFFFFFFF -> pc_src_out=1, branch_target_out=0xFC.
- Same with bne=1 instead -> pc_src_out=0.
REQ-038 Forwarding:
- Cycle 1 produces alu_result_out=0x10.
- Cycle 2: fwd_a=01, fwd_b=10, wb_data=0x22, ALUOp=00 -> alu_result_out=0x32.
REQ-039 Stall/flush:
- stall=1 for 3 cycles -> outputs unchanged.
- flush=1 together with stall=1 -> all outputs 0.
REQ-040 Reset and corner operations:
- rst_n=0 with non-zero inputs -> all outputs 0 on that edge.
- slt with rs=0x80000000, rt=1 -> result 1.
- sll of B=1 with shamt=31 -> 0x80000000.
